// File: rtl/ground_check_scheduler_pkg.sv
// Shared widths, the checker range limit and the result FIFO entry layout
// for the ground-check scheduler.
package ground_check_scheduler_pkg;

  localparam int GRD_COORD_W = 18;
  localparam int GRD_OUT_W   = 10;
  localparam int GRD_LIMIT   = 320;

  typedef struct packed {
    logic                 id;
    logic [GRD_OUT_W-1:0] x;
    logic [GRD_OUT_W-1:0] y;
    logic [GRD_OUT_W-1:0] z;
    logic [GRD_OUT_W-1:0] p;
    logic                 en;
  } grd_entry_t;

  localparam int GRD_ENTRY_W = $bits(grd_entry_t);

endpackage

// File: rtl/ground_check_scheduler_fifo.sv
// Result FIFO for the ground-check scheduler. Depth must be a power of two so
// the pointers wrap naturally; overflow is prevented upstream by credits.
module ground_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  assign rdata  = mem[rd_ptr];

  // Storage carries no reset; contents are only observed while valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_pop)      count <= count + 1'b1;
      else if (!push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ground_check_scheduler.sv
// Two-requester round-robin front end for a shared 1-cycle ground-validity
// checker, with a tag pipeline and a credit-protected result FIFO.
module ground_check_scheduler
  import ground_check_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic signed [GRD_COORD_W-1:0] req0_x,
  input  logic signed [GRD_COORD_W-1:0] req0_y,
  input  logic signed [GRD_COORD_W-1:0] req0_z,
  input  logic signed [GRD_OUT_W-1:0]   req0_p,
  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic signed [GRD_COORD_W-1:0] req1_x,
  input  logic signed [GRD_COORD_W-1:0] req1_y,
  input  logic signed [GRD_COORD_W-1:0] req1_z,
  input  logic signed [GRD_OUT_W-1:0]   req1_p,
  output logic signed [GRD_COORD_W-1:0] chk_x,
  output logic signed [GRD_COORD_W-1:0] chk_y,
  output logic signed [GRD_COORD_W-1:0] chk_z,
  output logic signed [GRD_OUT_W-1:0]   chk_p,
  input  logic signed [GRD_OUT_W-1:0]   chk_out_x,
  input  logic signed [GRD_OUT_W-1:0]   chk_out_y,
  input  logic signed [GRD_OUT_W-1:0]   chk_out_z,
  input  logic signed [GRD_OUT_W-1:0]   chk_out_p,
  input  logic                        chk_out_en,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        res_id,
  output logic signed [GRD_OUT_W-1:0]   res_x,
  output logic signed [GRD_OUT_W-1:0]   res_y,
  output logic signed [GRD_OUT_W-1:0]   res_z,
  output logic signed [GRD_OUT_W-1:0]   res_p,
  output logic                        res_en,
  output logic [15:0]                 rej_cnt,
  output logic [15:0]                 acc_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 2;

  logic                       s1_vld, s2_vld;
  logic                       s1_id, s2_id;
  logic                       last_grant;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [CW-1:0]              in_use;
  logic                       has_credit;
  logic                       xfer0, xfer1, xfer;
  grd_entry_t                 wr_e, rd_e;
  logic [GRD_ENTRY_W-1:0]     fifo_rdata;

  // Every sample in flight or buffered holds a slot; a pop this cycle does not free one yet.
  assign in_use     = CW'(fifo_count) + CW'(s1_vld) + CW'(s2_vld);
  assign has_credit = !rst && (in_use < CW'(FIFO_DEPTH));

  // last_grant==1 means requester 0 wins a tie.
  assign req0_ready = has_credit && req0_valid && (!req1_valid || last_grant);
  assign req1_ready = has_credit && req1_valid && (!req0_valid || !last_grant);

  assign xfer0 = req0_valid && req0_ready;
  assign xfer1 = req1_valid && req1_ready;
  assign xfer  = xfer0 || xfer1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_x      <= '0;
      chk_y      <= '0;
      chk_z      <= '0;
      chk_p      <= '1;
      s1_vld     <= 1'b0;
      s1_id      <= 1'b0;
      s2_vld     <= 1'b0;
      s2_id      <= 1'b0;
      last_grant <= 1'b1;
      acc_cnt    <= '0;
      rej_cnt    <= '0;
    end else begin
      s1_vld <= xfer;
      s2_vld <= s1_vld;
      s2_id  <= s1_id;
      if (xfer) begin
        s1_id      <= xfer1;
        last_grant <= xfer1;
        acc_cnt    <= acc_cnt + 16'd1;
        chk_x      <= xfer1 ? req1_x : req0_x;
        chk_y      <= xfer1 ? req1_y : req0_y;
        chk_z      <= xfer1 ? req1_z : req0_z;
        chk_p      <= xfer1 ? req1_p : req0_p;
      end
      if (s2_vld && !chk_out_en) rej_cnt <= rej_cnt + 16'd1;
    end
  end

  assign wr_e = '{id: s2_id, x: chk_out_x, y: chk_out_y, z: chk_out_z,
                  p: chk_out_p, en: chk_out_en};

  ground_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (GRD_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s2_vld),
    .wdata (wr_e),
    .pop   (res_ready),
    .rdata (fifo_rdata),
    .valid (res_valid),
    .count (fifo_count)
  );

  assign rd_e   = grd_entry_t'(fifo_rdata);
  assign res_id = rd_e.id;
  assign res_x  = rd_e.x;
  assign res_y  = rd_e.y;
  assign res_z  = rd_e.z;
  assign res_p  = rd_e.p;
  assign res_en = rd_e.en;

endmodule

// File: tb/tb_ground_check_scheduler.sv
// Bench for ground_check_scheduler: a depth-4 instance checked against a
// queue-based model, plus a depth-8 instance for the deep reset scenario.
module tb_ground_check_scheduler;
  import ground_check_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic req0_valid = 0, req1_valid = 0, res_ready = 0;
  logic signed [17:0] req0_x = 0, req0_y = 0, req0_z = 0, req1_x = 0, req1_y = 0, req1_z = 0;
  logic signed [9:0]  req0_p = 0, req1_p = 0;

  logic req0_ready, req1_ready, res_valid, res_id, res_en;
  logic signed [17:0] chk_x, chk_y, chk_z;
  logic signed [9:0]  chk_p, c_x, c_y, c_z, c_p, res_x, res_y, res_z, res_p;
  logic c_en;
  logic [15:0] rej_cnt, acc_cnt;

  logic d8_r0, d8_r1, d8_res_valid, d8_res_id, d8_res_en;
  logic signed [17:0] d8_chk_x, d8_chk_y, d8_chk_z;
  logic signed [9:0]  d8_chk_p, d8_cx, d8_cy, d8_cz, d8_cp, d8_rx, d8_ry, d8_rz, d8_rp;
  logic d8_cen;
  logic [15:0] d8_rej, d8_acc;

  ground_check_scheduler #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req0_z(req0_z), .req0_p(req0_p),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x(req1_x), .req1_y(req1_y), .req1_z(req1_z), .req1_p(req1_p),
    .chk_x(chk_x), .chk_y(chk_y), .chk_z(chk_z), .chk_p(chk_p),
    .chk_out_x(c_x), .chk_out_y(c_y), .chk_out_z(c_z), .chk_out_p(c_p), .chk_out_en(c_en),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_x(res_x), .res_y(res_y), .res_z(res_z), .res_p(res_p), .res_en(res_en),
    .rej_cnt(rej_cnt), .acc_cnt(acc_cnt));

  ground_check_scheduler #(.FIFO_DEPTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(d8_r0),
    .req0_x(req0_x), .req0_y(req0_y), .req0_z(req0_z), .req0_p(req0_p),
    .req1_valid(req1_valid), .req1_ready(d8_r1),
    .req1_x(req1_x), .req1_y(req1_y), .req1_z(req1_z), .req1_p(req1_p),
    .chk_x(d8_chk_x), .chk_y(d8_chk_y), .chk_z(d8_chk_z), .chk_p(d8_chk_p),
    .chk_out_x(d8_cx), .chk_out_y(d8_cy), .chk_out_z(d8_cz), .chk_out_p(d8_cp),
    .chk_out_en(d8_cen),
    .res_valid(d8_res_valid), .res_ready(res_ready), .res_id(d8_res_id),
    .res_x(d8_rx), .res_y(d8_ry), .res_z(d8_rz), .res_p(d8_rp), .res_en(d8_res_en),
    .rej_cnt(d8_rej), .acc_cnt(d8_acc));

  // Checker behaviour: in range -> coordinates pass through, else all -1 with en=0.
  function automatic logic [40:0] chk_f(input logic signed [17:0] x, y, z,
                                        input logic signed [9:0] p);
    if (x >= -GRD_LIMIT && x <= GRD_LIMIT && y >= -GRD_LIMIT && y <= GRD_LIMIT &&
        z >= -GRD_LIMIT && z <= GRD_LIMIT)
      return {1'b1, x[9:0], y[9:0], z[9:0], p};
    return {1'b0, {40{1'b1}}};
  endfunction

  always @(posedge clk) begin
    {c_en, c_x, c_y, c_z, c_p}       <= chk_f(chk_x, chk_y, chk_z, chk_p);
    {d8_cen, d8_cx, d8_cy, d8_cz, d8_cp} <= chk_f(d8_chk_x, d8_chk_y, d8_chk_z, d8_chk_p);
  end

  int errors = 0, checks = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: outstanding results in acceptance order, each stamped with its transfer edge.
  typedef struct {
    logic        id;
    logic [40:0] res;
    int          e;
  } item_t;
  item_t q[$];
  int    n = 0;
  bit    m_last = 1;
  int    acc_tot = 0, rej_tot = 0;

  function automatic logic signed [17:0] rc();
    int v;
    if ($urandom_range(0, 7) == 0) v = int'($urandom_range(0, 2000)) - 1000;
    else v = int'($urandom_range(0, 640)) - 320;
    return 18'(v);
  endfunction

  task automatic rand_samples();
    req0_x = rc(); req0_y = rc(); req0_z = rc(); req0_p = 10'($urandom);
    req1_x = rc(); req1_y = rc(); req1_z = rc(); req1_p = 10'($urandom);
  endtask

  task automatic step(input bit v0, input bit v1, input bit rr, output bit o0, output bit o1);
    bit ok, e0, e1, ev;
    item_t it;
    req0_valid = v0; req1_valid = v1; res_ready = rr;
    #1;
    o0 = req0_ready; o1 = req1_ready;
    ok = q.size() < 4;
    e0 = ok && v0 && (!v1 || m_last);
    e1 = ok && v1 && (!v0 || !m_last);
    check("req0_ready", 64'(req0_ready), 64'(e0));
    check("req1_ready", 64'(req1_ready), 64'(e1));
    ev = (q.size() > 0) && (n >= q[0].e + 2);
    check("res_valid", 64'(res_valid), 64'(ev));
    if (ev) check("res_data", {res_id, res_en, res_x, res_y, res_z, res_p}, {q[0].id, q[0].res});
    check("acc_cnt", 64'(acc_cnt), 64'(16'(acc_tot)));
    check("rej_cnt", 64'(rej_cnt), 64'(16'(rej_tot)));
    @(posedge clk);
    n++;
    if (ev && rr) void'(q.pop_front());
    if (e0 || e1) begin
      it.id  = e1;
      it.res = e1 ? chk_f(req1_x, req1_y, req1_z, req1_p) : chk_f(req0_x, req0_y, req0_z, req0_p);
      it.e   = n;
      q.push_back(it);
      m_last = e1;
      acc_tot++;
    end
    foreach (q[i]) if (q[i].e == n - 2 && !q[i].res[40]) rej_tot++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; req0_valid = 1; req1_valid = 1; res_ready = 1;
    #1;
    check("rst_ready", {req0_ready, req1_ready, d8_r0, d8_r1}, 0);
    check("rst_res_valid", {res_valid, d8_res_valid}, 0);
    check("rst_counters", {acc_cnt, rej_cnt, d8_acc, d8_rej}, 0);
    check("rst_chk_xyz", {chk_x, chk_y, chk_z}, 0);
    check("rst_chk_p", {chk_p}, 64'h3FF);
    @(negedge clk); @(negedge clk);
    rst = 0; req0_valid = 0; req1_valid = 0;
    q.delete(); m_last = 1; acc_tot = 0; rej_tot = 0;
  endtask

  typedef struct {
    bit v0, v1, rr;
    bit r0, r1;
  } vec_t;

  initial begin
    vec_t tbl[7];
    bit o0, o1;
    int cnt;
    tbl[0] = '{1, 1, 1, 1, 0};
    tbl[1] = '{1, 1, 1, 0, 1};
    tbl[2] = '{0, 1, 1, 0, 1};
    tbl[3] = '{1, 1, 1, 1, 0};
    tbl[4] = '{0, 0, 1, 0, 0};
    tbl[5] = '{1, 0, 1, 1, 0};
    tbl[6] = '{1, 1, 1, 0, 1};

    @(negedge clk);
    do_reset();

    // Arbitration table from reset.
    for (int i = 0; i < 7; i++) begin
      rand_samples();
      step(tbl[i].v0, tbl[i].v1, tbl[i].rr, o0, o1);
      check($sformatf("tbl%0d_ready", i), {o0, o1}, {tbl[i].r0, tbl[i].r1});
    end
    for (int i = 0; i < 4; i++) step(0, 0, 1, o0, o1);

    // Single in-range request, 2-cycle latency.
    do_reset();
    req0_x = 10; req0_y = 20; req0_z = 5; req0_p = 3;
    step(1, 0, 1, o0, o1);
    check("single_xfer", 64'(o0), 1);
    step(0, 0, 1, o0, o1);
    check("single_early", 64'(res_valid), 0);
    step(0, 0, 1, o0, o1);
    check("single_valid", 64'(res_valid), 1);
    check("single_data", {res_id, res_en, res_x, res_y, res_z, res_p},
          {1'b0, 1'b1, 10'd10, 10'd20, 10'd5, 10'd3});
    check("single_acc", 64'(acc_cnt), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, o0, o1);

    // Both valid continuously: strict alternation, one transfer per clock.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      rand_samples();
      step(1, 1, 1, o0, o1);
      check($sformatf("alt%0d", i), {o0, o1}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 1, o0, o1);

    // Back-pressure: credits stop req0 after FIFO_DEPTH transfers.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      rand_samples();
      step(1, 0, 0, o0, o1);
      cnt += int'(o0);
    end
    check("fill_xfers", 64'(cnt), 4);
    check("fill_stalled", 64'(o0), 0);
    for (int i = 0; i < 12; i++) begin
      rand_samples();
      step(1, 0, 1, o0, o1);
    end
    for (int i = 0; i < 6; i++) step(0, 0, 1, o0, o1);

    // Out-of-range request.
    do_reset();
    req0_x = 321; req0_y = 0; req0_z = 0; req0_p = 7;
    step(1, 0, 1, o0, o1);
    step(0, 0, 1, o0, o1);
    step(0, 0, 1, o0, o1);
    check("oor_data", {res_id, res_en, res_x, res_y, res_z, res_p}, {1'b0, 1'b0, {40{1'b1}}});
    check("oor_rej", 64'(rej_cnt), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, o0, o1);

    // Reset with 3 buffered and 2 in flight (depth-8 instance).
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rand_samples();
      step(1, 0, 0, o0, o1);
    end
    check("deep_acc", 64'(d8_acc), 5);
    check("deep_buffered", 64'(d8_res_valid), 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, o0, o1);
      check($sformatf("deep_stale%0d", i), 64'(d8_res_valid), 0);
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    check("deep_first_grant", {d8_r0, d8_r1}, 2'b10);
    rand_samples();
    step(1, 1, 1, o0, o1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, o0, o1);

    // Randomized traffic against the model, with one mid-run reset.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      rand_samples();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) < 7, o0, o1);
    end
    for (int i = 0; i < 10; i++) step(0, 0, 1, o0, o1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ground_check_scheduler.md
GROUND_CHECK_SCHEDULER -- requirements
Module: ground_check_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, result FIFO entries; legal values are powers of two, at least 2.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  in  1  requester n presents a sample.
REQ-005 req0_ready / req1_ready  out  1  scheduler accepts requester n's sample this cycle.
REQ-006 reqN_x, reqN_y, reqN_z  in  18 signed  each  requester n coordinates.
REQ-007 reqN_p  in  10 signed  requester n payload (pixel/plane index).
REQ-008 chk_x, chk_y, chk_z  out  18 signed  each  registered operands to the shared ground-validity checker.
REQ-009 chk_p  out  10 signed  registered payload to the checker.
REQ-010 chk_out_x, chk_out_y, chk_out_z, chk_out_p  in  10 signed  each  checker results.
REQ-011 chk_out_en  in  1  checker result enable; checker latency is fixed at 1 clk, with no stall.
REQ-012 res_valid  out  1  FIFO head is valid; res_ready  in  1  consumer pops the head.
REQ-013 res_id  out  1  originating requester; res_x, res_y, res_z, res_p  out  10 signed  each; res_en  out  1.
REQ-014 rej_cnt  out  16  count of results captured with chk_out_en=0.
REQ-015 acc_cnt  out  16  count of accepted requests.

Function
REQ-016 Handshake: a transfer on requester n occurs on an edge where reqN_valid and reqN_ready are both 1; reqN_ready may depend combinationally on both valids.
REQ-017 Credit = FIFO_DEPTH - fifo_count - s1_vld - s2_vld; ready is asserted only when credit > 0; a same-cycle pop is not credited.
REQ-018 Round-robin arbitration: when only one valid, it is granted; when both are valid, the requester that was not granted last is granted; at most one ready is high per cycle.
REQ-019 last_grant updates only on a transfer.
REQ-020 On a transfer at edge E, chk_* load the granted sample, s1_vld=1, and s1_id=grant; otherwise chk_* hold their values and s1_vld=0.
REQ-021 At E+1, s2_vld and s2_id copy s1; at E+2, if s2_vld, {s2_id, chk_out_*} is written to the FIFO.
REQ-022 Latency from transfer to res_valid with an empty FIFO is exactly 2 clk; sustained throughput is 1 sample/clk.
REQ-023 Checker outputs captured while s2_vld=0 are ignored.
REQ-024 Results leave the FIFO in acceptance order; a pop occurs when res_valid and res_ready are both 1.
REQ-025 A simultaneous push and pop leaves fifo_count unchanged.
REQ-026 Pointers wrap modulo FIFO_DEPTH.
REQ-027 The FIFO never overflows, guaranteed by REQ-017.
REQ-028 res_* are undefined when res_valid=0.
REQ-029 rej_cnt increments on a FIFO write with chk_out_en=0; acc_cnt increments on each transfer; both wrap from 0xFFFF to 0.

Reset
REQ-030 While rst=1, all of the following hold: both readies=0, res_valid=0, s1_vld=s2_vld=0, FIFO empty, last_grant=1 (requester 0 wins first), rej_cnt=acc_cnt=0, chk_x/y/z=0, chk_p=-1.
REQ-031 Reset asserted mid-operation discards in-flight and buffered results without emitting them; the first transfer after release behaves as after power-up.

Structure
REQ-032 A shared package holds GRD_COORD_W=18, GRD_OUT_W=10, GRD_LIMIT=320, and the FIFO entry record (id, x, y, z, p, en).
REQ-033 The result FIFO is a sub-module, ground_result_fifo, parameterised by depth and entry width.
REQ-034 Arbitration, credit accounting, and the tag pipeline remain in the top module.

Verification
REQ-035 Single request: req0 (x=10, y=20, z=5, p=3) with res_ready=1 -> res_valid exactly 2 clk after the transfer, with res_id=0, res_x=10, res_y=20, res_z=5, res_p=3, res_en=1, acc_cnt=1.
REQ-036 Both requesters valid continuously after reset -> grants alternate 0,1,0,1..., with one transfer per clk and results in the same order.
REQ-037 res_ready=0, req0 always valid, FIFO_DEPTH=4 -> exactly 4 transfers, then req0_ready=0; raising res_ready resumes transfers with no loss or duplication.
REQ-038 Out-of-range request x=321, y=0 -> result has res_en=0, res_p=-1, all coordinates -1, and rej_cnt increments by 1.
REQ-039 rst pulsed while 2 samples are in flight and 3 are buffered -> res_valid=0 immediately, no stale results afterwards, counters=0, and the next grant goes to req0.
